div_iter: RTL and testbench



---
 rtl/div_iter.sv | 153 +++++++++++++++
 tb/tb_div_iter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} 32 edges after a start is accepted, or
// a fixed all-zero result one edge after a start with a zero divisor.
module div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        DivFree,
        DivByZero,
        DivOn,
        DivEnd
    } div_state_t;

    div_state_t  state;
    div_state_t  state_next;

    logic [4:0]  cnt;
    logic [31:0] dvd_q;
    logic [32:0] rem_q;
    logic [31:0] dsr_q;
    logic        sgn_flag;
    logic        dvd_neg;
    logic        dsr_neg;

    logic        start_ok;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [33:0] rem_shift;
    logic [33:0] diff;
    logic        q_bit;
    logic [32:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // One restoring step plus operand magnitudes and final sign fix-up.
    // dvd_q shifts out dividend bits at the top while quotient bits enter
    // at the bottom, so after 32 steps it holds the unsigned quotient.
    always_comb begin
        start_ok  = start_i && !annul_i;
        abs_a     = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
        abs_b     = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
        rem_shift = {rem_q, dvd_q[31]};
        diff      = rem_shift - {2'b00, dsr_q};
        q_bit     = ~diff[33];
        rem_step  = q_bit ? diff[32:0] : rem_shift[32:0];
        quo_step  = {dvd_q[30:0], q_bit};
        quo_fix   = (sgn_flag && (dvd_neg ^ dsr_neg)) ? -quo_step : quo_step;
        rem_fix   = (sgn_flag && dvd_neg) ? -rem_step[31:0] : rem_step[31:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; annul wins over completion while dividing.
    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (start_ok) begin
                    state_next = (opdata2_i == 32'd0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                state_next = DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else if (cnt == 5'd31) begin
                    state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (annul_i || !start_i) begin
                    state_next = DivFree;
                end
            end
            default: begin
                state_next = DivFree;
            end
        endcase
    end

    // Operand latching, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 5'd0;
            dvd_q    <= 32'd0;
            rem_q    <= 33'd0;
            dsr_q    <= 32'd0;
            sgn_flag <= 1'b0;
            dvd_neg  <= 1'b0;
            dsr_neg  <= 1'b0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                DivFree: begin
                    if (start_ok && (opdata2_i != 32'd0)) begin
                        dvd_q    <= abs_a;
                        dsr_q    <= abs_b;
                        rem_q    <= 33'd0;
                        sgn_flag <= signed_div_i;
                        dvd_neg  <= opdata1_i[31];
                        dsr_neg  <= opdata2_i[31];
                        cnt      <= 5'd0;
                    end
                end
                DivByZero: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b1;
                end
                DivOn: begin
                    if (!annul_i) begin
                        rem_q <= rem_step;
                        dvd_q <= quo_step;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                DivEnd: begin
                    if (annul_i || !start_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Testbench for div_iter: directed table, multi-cycle corner sequences and
// random operands checked against a plain-arithmetic division model.
module tb_div_iter;

    logic        clk;
    logic        rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] expected;
        bit          scramble;
        string       name;
    } vec_t;

    vec_t vecs[11];

    div_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: divide with 64-bit integers (truncating toward zero, as
    // MIPS does), zero result for a zero divisor, keep the low 32 bits.
    function automatic logic [63:0] refDiv(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na;
        longint nb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Full handshake: start, wait for ready (bounded), check latency, result,
    // hold stability, then drop start and check the clear.
    task automatic runDivision(input bit s, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] expected, input bit scramble, input string name);
        int lat;
        applyStimulus(s, a, b);
        @(posedge clk);
        #1;
        if (scramble) begin
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~signed_div_i;
        end
        lat = 0;
        while (!ready_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, " latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd32);
        checkOutput({name, " result"}, result_o, expected);
        @(posedge clk);
        #1;
        checkOutput({name, " hold"}, {ready_o, result_o[62:0]}, {1'b1, expected[62:0]});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, " ready drop"}, {63'd0, ready_o}, 64'd0);
        checkOutput({name, " result clear"}, result_o, 64'd0);
    endtask

    initial begin
        bit          sawReady;
        int          lat;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0, "divu_100_7"};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "div_m7_2"};
        vecs[2]  = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, "div_7_m2"};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "div_min_m1"};
        vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 1'b0, "divu_min_m1"};
        vecs[5]  = '{1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 1'b0, "divu_5_0"};
        vecs[6]  = '{1'b1, 32'hFFFFFFF8,   32'd0,        64'h00000000_00000000, 1'b0, "div_m8_0"};
        vecs[7]  = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b1, "divu_100_7_scramble"};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0, "div_m100_m7"};
        vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1'b0, "divu_max_1"};
        vecs[10] = '{1'b0, 32'd3,          32'd7,        64'h00000003_00000000, 1'b0, "divu_3_7"};

        rst_n        = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #12;
        checkOutput("reset ready", {63'd0, ready_o}, 64'd0);
        checkOutput("reset result", result_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            runDivision(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].expected, vecs[i].scramble, vecs[i].name);
        end

        // Annul ten cycles into a division: ready must never appear.
        applyStimulus(1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("annul ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i  = 1'b0;
        sawReady = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (ready_o) sawReady = 1'b1;
        end
        checkOutput("annul no ready", {63'd0, sawReady}, 64'd0);
        checkOutput("annul result", result_o, 64'd0);
        runDivision(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "divu_9_3_after_annul");

        // Reset while holding a finished result: outputs clear with no edge.
        applyStimulus(1'b0, 32'd100, 32'd7);
        lat = 0;
        while (!ready_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("pre-reset result", result_o, 64'h00000002_0000000E);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset ready", {63'd0, ready_o}, 64'd0);
        checkOutput("async reset result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a division, then a fresh start right after.
        applyStimulus(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset ready", {63'd0, ready_o}, 64'd0);
        opdata1_i = 32'd9;
        opdata2_i = 32'd3;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!ready_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("post reset latency", 64'(lat), 64'd32);
        checkOutput("post reset result", result_o, 64'h00000000_00000003);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom % 2);
            a = $urandom;
            case ($urandom % 4)
                0: b = $urandom;
                1: b = $urandom % 16;
                2: b = -($urandom % 16);
                default: b = $urandom >> ($urandom % 32);
            endcase
            runDivision(s, a, b, refDiv(s, a, b), 1'b0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
